// File: rtl/pe_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_seq
// Description : Sequential multiply-accumulate processing element. It computes
//               a dot product LANES terms per cycle, adds a bias, then shifts
//               and saturates the result. Defining PE_MAC_RELU_EN clamps
//               negative signed results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_seq #(
    parameter int N_TERMS = 27,
    parameter int DW      = 8,
    parameter int LANES   = 1,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   is_signed,
    input  logic [N_TERMS*DW-1:0]  weights_flat,
    input  logic [N_TERMS*DW-1:0]  inputs_flat,
    input  logic [ACC_W-1:0]       bias,
    input  logic [4:0]             shift,
    output logic [ACC_W-1:0]       acc_out,
    output logic [OUT_W-1:0]       mac_out,
    output logic                   sat,
    output logic                   busy,
    output logic                   done
);

    localparam int c_groups    = (N_TERMS + LANES - 1) / LANES;
    localparam int c_pad_terms = c_groups * LANES;
    localparam int c_grp_w     = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam logic [c_grp_w-1:0] c_last_grp = c_grp_w'(c_groups - 1);

    localparam logic signed [ACC_W-1:0] c_smax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_smin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]        c_umax = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

`ifdef PE_MAC_RELU_EN
    localparam bit c_relu = 1'b1;
`else
    localparam bit c_relu = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_is_signed;
    logic [N_TERMS*DW-1:0]    r_w;
    logic [N_TERMS*DW-1:0]    r_x;
    logic [ACC_W-1:0]         r_bias;
    logic [4:0]               r_shift;
    logic [ACC_W-1:0]         r_acc;
    logic [c_grp_w-1:0]       r_grp;
    logic [ACC_W-1:0]         r_acc_out;
    logic [OUT_W-1:0]         r_mac_out;
    logic                     r_sat;
    logic                     r_busy;
    logic                     r_done;

    logic [c_pad_terms*DW-1:0] w_w_pad;
    logic [c_pad_terms*DW-1:0] w_x_pad;
    logic [31:0]               w_base;
    logic [LANES*DW-1:0]       w_grp_w;
    logic [LANES*DW-1:0]       w_grp_x;
    logic [ACC_W-1:0]          w_lane_prod [LANES];
    logic [ACC_W-1:0]          w_grp_sum;
    logic [ACC_W-1:0]          w_biased;
    logic signed [ACC_W-1:0]   w_sshift;
    logic [ACC_W-1:0]          w_ushift;
    logic [OUT_W-1:0]          w_mac;
    logic                      w_sat;

    // Zero-pad the operands to a whole number of groups so surplus lanes in the
    // last group multiply zeros instead of needing a bounds check.
    always_comb begin
        w_w_pad                   = '0;
        w_x_pad                   = '0;
        w_w_pad[N_TERMS*DW-1:0]   = r_w;
        w_x_pad[N_TERMS*DW-1:0]   = r_x;
    end

    assign w_base  = 32'(r_grp) * 32'(LANES * DW);
    assign w_grp_w = w_w_pad[w_base +: LANES*DW];
    assign w_grp_x = w_x_pad[w_base +: LANES*DW];

    // Each operand gets one extra bit (sign or zero) so a single signed
    // multiplier serves both signed and unsigned modes.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DW:0]     w_a;
        logic signed [DW:0]     w_b;
        logic signed [2*DW+1:0] w_p;
        assign w_a            = {r_is_signed & w_grp_w[l*DW+DW-1], w_grp_w[l*DW +: DW]};
        assign w_b            = {r_is_signed & w_grp_x[l*DW+DW-1], w_grp_x[l*DW +: DW]};
        assign w_p            = w_a * w_b;
        assign w_lane_prod[l] = ACC_W'(w_p);
    end

    always_comb begin
        w_grp_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_grp_sum = w_grp_sum + w_lane_prod[l];
        end
    end

    assign w_biased = r_acc + r_bias;
    assign w_sshift = $signed(w_biased) >>> r_shift;
    assign w_ushift = w_biased >> r_shift;

    always_comb begin
        w_mac = '0;
        w_sat = 1'b0;
        if (r_is_signed) begin
            if (c_relu && (w_sshift < 0)) begin
                w_mac = '0;
                w_sat = 1'b0;
            end else if (w_sshift > c_smax) begin
                w_mac = c_smax[OUT_W-1:0];
                w_sat = 1'b1;
            end else if (w_sshift < c_smin) begin
                w_mac = c_smin[OUT_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_mac = w_sshift[OUT_W-1:0];
            end
        end else begin
            if (w_ushift > c_umax) begin
                w_mac = c_umax[OUT_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_mac = w_ushift[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_signed <= 1'b0;
            r_w         <= '0;
            r_x         <= '0;
            r_bias      <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_grp       <= '0;
            r_acc_out   <= '0;
            r_mac_out   <= '0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_signed <= is_signed;
                        r_w         <= weights_flat;
                        r_x         <= inputs_flat;
                        r_bias      <= bias;
                        r_shift     <= shift;
                        r_acc       <= '0;
                        r_grp       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + w_grp_sum;
                    if (r_grp == c_last_grp) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                S_FINAL: begin
                    r_acc_out <= w_biased;
                    r_mac_out <= w_mac;
                    r_sat     <= w_sat;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign acc_out = r_acc_out;
    assign mac_out = r_mac_out;
    assign sat     = r_sat;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_seq
// Description : Directed self-checking bench for pe_mac_seq (default build and
//               a LANES=4 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_seq;

    localparam int N     = 27;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;
`ifdef PE_MAC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, is_signed;
    logic [N*DW-1:0]    weights_flat, inputs_flat;
    logic [ACC_W-1:0]   bias;
    logic [4:0]         shift;
    logic [ACC_W-1:0]   acc_out;
    logic [OUT_W-1:0]   mac_out;
    logic               sat, busy, done;

    logic               start4;
    logic [N*DW-1:0]    weights4, inputs4;
    logic [ACC_W-1:0]   bias4;
    logic [ACC_W-1:0]   acc_out4;
    logic [OUT_W-1:0]   mac_out4;
    logic               sat4, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int cnt;
    logic [OUT_W-1:0] mac_c1;
    logic             busy_c1;

    always #5 clk = ~clk;

    pe_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .weights_flat(weights_flat), .inputs_flat(inputs_flat), .bias(bias),
        .shift(shift), .acc_out(acc_out), .mac_out(mac_out), .sat(sat),
        .busy(busy), .done(done)
    );

    pe_mac_seq #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(1'b0),
        .weights_flat(weights4), .inputs_flat(inputs4), .bias(bias4),
        .shift(5'd0), .acc_out(acc_out4), .mac_out(mac_out4), .sat(sat4),
        .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts an operation in the current (IDLE) cycle; returns the cycle index
    // at which done is seen, with the start cycle as index 0.
    task automatic do_op(input logic s, input logic [7:0] w, input logic [7:0] x,
                         input logic [ACC_W-1:0] b, input logic [4:0] sh,
                         input int inject_at);
        is_signed = s;
        for (int i = 0; i < N; i++) begin
            weights_flat[i*DW +: DW] = w;
            inputs_flat[i*DW +: DW]  = x;
        end
        bias  = b;
        shift = sh;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 1;
        mac_c1  = mac_out;
        busy_c1 = busy;
        while (!done && lat < 100) begin
            if (lat == inject_at) begin
                start = 1'b1;
                for (int i = 0; i < N; i++) weights_flat[i*DW +: DW] = 8'h02;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic do_op4(input logic [ACC_W-1:0] b);
        weights4 = '0;
        inputs4  = '0;
        for (int i = 0; i < 9; i++) begin
            weights4[i*DW +: DW] = 8'd2;
            inputs4[i*DW +: DW]  = 8'd3;
        end
        bias4  = b;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat    = 1;
        while (!done4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_done(input int n);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
        weights_flat = '0; inputs_flat = '0; bias = '0; shift = '0;
        start4 = 1'b0; weights4 = '0; inputs4 = '0; bias4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc", 32'(acc_out), 32'h0);
        check("rst_mac", 32'(mac_out), 32'h0);
        check("rst_sat", 32'(sat), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        // unsigned 1x1, start issued right after reset release
        do_op(1'b0, 8'd1, 8'd1, '0, 5'd0, -1);
        check("u1_latency", 32'(lat), 32'd29);
        check("u1_busy_run", 32'(busy_c1), 32'h1);
        check("u1_busy_done", 32'(busy), 32'h0);
        check("u1_acc", 32'(acc_out), 32'd27);
        check("u1_mac", 32'(mac_out), 32'd27);
        check("u1_sat", 32'(sat), 32'h0);
        @(posedge clk); #1;
        check("u1_done_pulse", 32'(done), 32'h0);
        check("u1_mac_hold", 32'(mac_out), 32'd27);

        // signed -1 x 3
        do_op(1'b1, 8'hFF, 8'd3, '0, 5'd0, -1);
        check("s1_mac_prev", 32'(mac_c1), 32'd27);
        check("s1_latency", 32'(lat), 32'd29);
        check("s1_acc", 32'(acc_out), 32'hFFFFAF);
        check("s1_mac", 32'(mac_out), RELU ? 32'h0 : 32'hAF);
        check("s1_sat", 32'(sat), 32'h0);
        @(posedge clk); #1;

        // signed 127 x 127: positive saturation, then shift 12
        do_op(1'b1, 8'd127, 8'd127, '0, 5'd0, -1);
        check("s2_acc", 32'(acc_out), 32'd435483);
        check("s2_mac", 32'(mac_out), 32'd127);
        check("s2_sat", 32'(sat), 32'h1);
        @(posedge clk); #1;
        do_op(1'b1, 8'd127, 8'd127, '0, 5'd12, -1);
        check("s3_mac", 32'(mac_out), 32'd106);
        check("s3_sat", 32'(sat), 32'h0);
        @(posedge clk); #1;

        // signed -128 x 127: negative saturation (or ReLU zero)
        do_op(1'b1, 8'h80, 8'd127, '0, 5'd0, -1);
        check("s4_acc", 32'(acc_out), 32'hF94D80);
        check("s4_mac", 32'(mac_out), RELU ? 32'h0 : 32'h80);
        check("s4_sat", 32'(sat), RELU ? 32'h0 : 32'h1);
        @(posedge clk); #1;

        // unsigned 255 x 255: saturation, then shift 16 brings it in range
        do_op(1'b0, 8'hFF, 8'hFF, '0, 5'd0, -1);
        check("u2_acc", 32'(acc_out), 32'h1ACA1B);
        check("u2_mac", 32'(mac_out), 32'hFF);
        check("u2_sat", 32'(sat), 32'h1);
        @(posedge clk); #1;
        do_op(1'b0, 8'hFF, 8'hFF, '0, 5'd16, -1);
        check("u3_mac", 32'(mac_out), 32'd26);
        check("u3_sat", 32'(sat), 32'h0);
        @(posedge clk); #1;

        // start re-pulsed mid-RUN with altered operands is ignored
        do_op(1'b0, 8'd1, 8'd1, '0, 5'd0, 5);
        check("inj_latency", 32'(lat), 32'd29);
        check("inj_mac", 32'(mac_out), 32'd27);
        count_done(40);
        check("inj_extra_done", 32'(cnt), 32'd0);

        // back-to-back: second start in the IDLE cycle after done
        do_op(1'b0, 8'd1, 8'd2, '0, 5'd0, -1);
        check("b2b_a_mac", 32'(mac_out), 32'd54);
        @(posedge clk); #1;
        do_op(1'b0, 8'd1, 8'd3, '0, 5'd0, -1);
        check("b2b_hold", 32'(mac_c1), 32'd54);
        check("b2b_latency", 32'(lat), 32'd29);
        check("b2b_b_mac", 32'(mac_out), 32'd81);
        @(posedge clk); #1;

        // asynchronous reset mid-RUN aborts the operation
        is_signed = 1'b0;
        for (int i = 0; i < N; i++) begin
            weights_flat[i*DW +: DW] = 8'd1;
            inputs_flat[i*DW +: DW]  = 8'd1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", 32'(acc_out), 32'h0);
        check("mid_rst_mac", 32'(mac_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_done(40);
        check("mid_rst_no_done", 32'(cnt), 32'd0);
        check("mid_rst_mac_after", 32'(mac_out), 32'h0);

        do_op(1'b0, 8'd2, 8'd2, '0, 5'd0, -1);
        check("post_rst_latency", 32'(lat), 32'd29);
        check("post_rst_mac", 32'(mac_out), 32'd108);

        // LANES=4 instance: 9 non-zero terms, G=7
        do_op4('0);
        check("l4_latency", 32'(lat), 32'd9);
        check("l4_mac", 32'(mac_out4), 32'd54);
        check("l4_acc", 32'(acc_out4), 32'd54);
        @(posedge clk); #1;
        do_op4(24'd10);
        check("l4_bias_mac", 32'(mac_out4), 32'd64);
        check("l4_bias_sat", 32'(sat4), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_mac_seq.md
PE_MAC_SEQ -- requirements
Module: pe_mac_seq

Interface
Parameters:
REQ-001 N_TERMS, 27, number of weight/input products per dot product (>=1).
REQ-002 DW, 8, operand width per term.
REQ-003 LANES, 1, products accumulated per RUN cycle (1..N_TERMS).
REQ-004 ACC_W, 24, accumulator width (>= 2*DW).
REQ-005 OUT_W, 8, width of the requantised output.

Ports:
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle request; accepted only in IDLE.
REQ-009 is_signed  in  1  1 = two's-complement operands/bias, 0 = unsigned; sampled on accepted start.
REQ-010 weights_flat  in  N_TERMS*DW  term i at [i*DW +: DW]; sampled on accepted start.
REQ-011 inputs_flat  in  N_TERMS*DW  same packing as weights_flat; sampled on accepted start.
REQ-012 bias  in  ACC_W  added after accumulation; sampled on accepted start.
REQ-013 shift  in  5  right-shift amount for requantisation; sampled on accepted start.
REQ-014 acc_out  out  ACC_W  raw accumulator + bias.
REQ-015 mac_out  out  OUT_W  shifted, saturated result.
REQ-016 sat  out  1  mac_out was clamped.
REQ-017 busy  out  1  high from the cycle after start is accepted until done.
REQ-018 done  out  1  one-cycle pulse; results valid.

Function
REQ-019 FSM states: IDLE, RUN, FINAL, DONE. IDLE->RUN on start; RUN->FINAL after the last group; FINAL->DONE; DONE->IDLE unconditionally.
REQ-020 On accepted start: latch all sampled inputs, clear accumulator and group counter.
REQ-021 RUN: each cycle adds LANES products of group g (terms g*LANES..g*LANES+LANES-1); RUN lasts G = ceil(N_TERMS/LANES) cycles.
REQ-022 Lanes indexing past N_TERMS-1 in the last group contribute zero.
REQ-023 Products: DW x DW -> 2*DW, signed or unsigned per latched is_signed; sign-/zero-extended to ACC_W; accumulator wraps modulo 2^ACC_W (no saturation).
REQ-024 FINAL: acc_out <= acc + bias; value arithmetic (signed) or logical (unsigned) shifted right by shift; clamped to OUT_W range ([-2^(OUT_W-1), 2^(OUT_W-1)-1] signed, [0, 2^OUT_W-1] unsigned); sat=1 iff clamped.
REQ-025 DONE: done=1 for exactly one cycle; busy=0 in that cycle.
REQ-026 Latency: start sampled at edge k -> done high in cycle k+G+2; with defaults, 29 cycles.
REQ-027 acc_out, mac_out, sat hold until the next accepted start, then hold previous values until the next done.
REQ-028 start while not in IDLE (RUN/FINAL/DONE) is ignored; no effect on the current operation.
REQ-029 start in the cycle after done (IDLE) is accepted; back-to-back operations allowed.

Reset
REQ-030 rst_n low asynchronously forces IDLE; busy, done, sat, acc_out, mac_out, accumulator, counter all 0.
REQ-031 Reset mid-RUN aborts the operation; no done pulse is produced for it.
REQ-032 After rst_n rises, the first start is accepted at the next rising edge.

Configuration
REQ-033 Macro PE_MAC_RELU_EN: when defined, negative post-shift values are clamped to 0 (sat=0 for this clamp) before saturation; when undefined, no ReLU, behaviour per REQ-024.

Verification (defaults unless stated, bias=0, shift=0)
REQ-034 Unsigned, all w=1,x=1 -> mac_out=27, acc_out=27, sat=0, done 29 cycles after start.
REQ-035 Signed, all w=-1,x=3 -> acc_out=-81 (0xFFFFAF), mac_out=0xAF, sat=0; with PE_MAC_RELU_EN mac_out=0.
REQ-036 Signed, all w=127,x=127 -> acc_out=435483, mac_out=127, sat=1; shift=12 -> mac_out=106, sat=0.
REQ-037 LANES=4, unsigned, terms 0..8 w=2,x=3, rest 0 -> mac_out=54; done 9 cycles after start (G=7); bias=10 -> mac_out=64.
REQ-038 start pulsed again mid-RUN -> single done, result of first operation; rst_n low mid-RUN -> no done, all outputs 0.
REQ-039 Back-to-back: start in IDLE cycle after done with new operands -> second correct result, mac_out holds first result until second done.
